// File: rtl/lock_pkg.sv
// Shared types and constants for the lock-protected register front-end.
package lock_pkg;
  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WRITE,
    RESP
  } state_t;

  localparam int DATA_W = 16;

  localparam logic RESP_OK     = 1'b0;
  localparam logic RESP_DENIED = 1'b1;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         resetn,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end
endmodule

// File: rtl/lock_write_sequencer.sv
// Request front-end: trust/lock policy, write strobe, response, violations.
module lock_write_sequencer #(
  parameter int DATA_W = lock_pkg::DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              Clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_trusted,
  input  logic              req_lock,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              lock_cmd,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [CNT_W-1:0]  viol_count
);
  import lock_pkg::*;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              trusted_q, trusted_d;
  logic              lreq_q, lreq_d;
  logic              lock_q, lock_d;
  logic              err_q, err_d;
  logic              viol_inc;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    trusted_d = trusted_q;
    lreq_d    = lreq_q;
    lock_d    = lock_q;
    err_d     = err_q;
    viol_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          data_d    = req_data;
          trusted_d = req_trusted;
          lreq_d    = req_lock;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (lreq_q) begin
          lock_d  = 1'b1;
          err_d   = RESP_OK;
          state_d = RESP;
        end else if (!lock_q || trusted_q) begin
          state_d = WRITE;
        end else begin
          err_d    = RESP_DENIED;
          viol_inc = 1'b1;
          state_d  = RESP;
        end
      end
      WRITE: begin
        err_d   = RESP_OK;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      data_q     <= '0;
      trusted_q  <= 1'b0;
      lreq_q     <= 1'b0;
      lock_q     <= 1'b0;
      err_q      <= RESP_OK;
      req_ready  <= 1'b0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      trusted_q  <= trusted_d;
      lreq_q     <= lreq_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
      req_ready  <= (state_d == IDLE);
      wr_en      <= (state_d == WRITE);
      if (state_d == WRITE) begin
        wr_data <= data_q;
      end
      resp_valid <= (state_d == RESP);
      resp_err   <= (state_d == RESP) ? err_d : RESP_OK;
    end
  end

  assign lock_cmd = lock_q;

  sat_counter #(
    .W(CNT_W)
  ) u_viol (
    .Clk   (Clk),
    .resetn(resetn),
    .inc   (viol_inc),
    .count (viol_count)
  );
endmodule

// File: tb/tb_lock_write_sequencer.sv
// Directed plus randomized check of lock_write_sequencer against a trace model.
module tb_lock_write_sequencer;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 2;
  localparam int VMAX   = (1 << CNT_W) - 1;

  logic              Clk;
  logic              resetn;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_data;
  logic              req_trusted;
  logic              req_lock;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              lock_cmd;
  logic              resp_valid;
  logic              resp_err;
  logic [CNT_W-1:0]  viol_count;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_locked;
  int m_viol;

  lock_write_sequencer #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .Clk        (Clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_trusted(req_trusted),
    .req_lock   (req_lock),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .lock_cmd   (lock_cmd),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .viol_count (viol_count)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and check the full response trace cycle by cycle.
  task automatic do_req(input logic [DATA_W-1:0] d, input logic t,
                        input logic l, input bit hold);
    int  w;
    int  rc;
    bit  denied;
    bit  wr;
    bit  lk_after;
    int  v_after;
    w = 0;
    while (req_ready !== 1'b1 && w < 10) begin
      @(negedge Clk);
      w++;
    end
    chk("ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid   = 1'b1;
    req_data    = d;
    req_trusted = t;
    req_lock    = l;
    denied   = !l && m_locked && !t;
    wr       = !l && !denied;
    rc       = wr ? 3 : 2;
    lk_after = m_locked | l;
    v_after  = (denied && m_viol < VMAX) ? m_viol + 1 : m_viol;
    @(posedge Clk);
    #1;
    if (!hold) req_valid = 1'b0;
    req_trusted = ~t;
    req_data    = DATA_W'($urandom);
    req_lock    = 1'($urandom);
    for (int c = 1; c <= rc + 1; c++) begin
      @(negedge Clk);
      chk("wr_en", {31'd0, wr_en}, {31'd0, wr && c == 2});
      if (wr && c == 2) chk("wr_data", {16'd0, wr_data}, {16'd0, d});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, c == rc});
      if (c == rc) chk("resp_err", {31'd0, resp_err}, {31'd0, denied});
      chk("lock_cmd", {31'd0, lock_cmd},
          {31'd0, (c >= 2) ? lk_after : m_locked});
      chk("viol_count", {30'd0, viol_count},
          32'((c >= 2) ? v_after : m_viol));
      chk("req_ready", {31'd0, req_ready}, {31'd0, c == rc + 1});
    end
    m_locked = lk_after;
    m_viol   = v_after;
  endtask

  initial begin
    bit hold;
    bit lk;
    req_valid   = 1'b0;
    req_data    = '0;
    req_trusted = 1'b0;
    req_lock    = 1'b0;
    resetn      = 1'b0;
    m_locked    = 1'b0;
    m_viol      = 0;
    #3;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
    chk("rst_lock", {31'd0, lock_cmd}, 32'd0);
    chk("rst_resp_v", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_e", {31'd0, resp_err}, 32'd0);
    chk("rst_viol", {30'd0, viol_count}, 32'd0);
    repeat (2) @(negedge Clk);
    resetn = 1'b1;
    @(negedge Clk);
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    do_req(16'hA5A5, 1'b0, 1'b0, 1'b0);
    do_req(16'h0000, 1'b0, 1'b1, 1'b0);
    do_req(16'h1234, 1'b0, 1'b0, 1'b0);
    do_req(16'hBEEF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_req(16'h1000 + 16'(i), 1'b0, 1'b0, 1'b0);
    chk("viol_sat", {30'd0, viol_count}, 32'(VMAX));
    do_req(16'h0000, 1'b0, 1'b1, 1'b0);

    do_req(16'h1111, 1'b1, 1'b0, 1'b1);
    do_req(16'h2222, 1'b0, 1'b0, 1'b1);
    do_req(16'h3333, 1'b0, 1'b1, 1'b1);
    do_req(16'h4444, 1'b1, 1'b0, 1'b0);

    // mid-WRITE reset while locked
    req_valid   = 1'b1;
    req_data    = 16'h5555;
    req_trusted = 1'b1;
    req_lock    = 1'b0;
    @(posedge Clk);
    #1 req_valid = 1'b0;
    @(posedge Clk);
    #1;
    chk("pre_rst_wr_en", {31'd0, wr_en}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("mid_rst_resp", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_lock", {31'd0, lock_cmd}, 32'd0);
    chk("mid_rst_viol", {30'd0, viol_count}, 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    chk("mid_rst_resp2", {31'd0, resp_valid}, 32'd0);
    resetn   = 1'b1;
    m_locked = 1'b0;
    m_viol   = 0;
    @(negedge Clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_viol", {30'd0, viol_count}, 32'd0);
    chk("post_rst_wr_en", {31'd0, wr_en}, 32'd0);
    do_req(16'h6789, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      hold = ($urandom_range(0, 3) == 0);
      lk   = ($urandom_range(0, 9) == 0);
      do_req(DATA_W'($urandom), 1'($urandom), lk, hold);
      if (!hold && $urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge Clk);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_wr_en", {31'd0, wr_en}, 32'd0);
      end
    end
    req_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lock_write_sequencer.md
Name: lock_write_sequencer

Overview:
- Upstream front-end for the 16-bit lock-protected data register.
- Accepts write and lock requests from the bus over a valid/ready handshake and tracks a sticky lock bit.
- Enforces trust policy: writes after lock are granted only to trusted requesters.
- Issues single-cycle write strobes plus write data and a lock command to the register stage. Returns a response and counts denied attempts.

Parameters:
DATA_W, 16, width of request data and register write data
CNT_W, 8, width of the saturating violation counter

Ports:
Clk  in  1  rising-edge clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept request
req_data  in  DATA_W  data to write
req_trusted  in  1  requester privilege, sampled with request
req_lock  in  1  request is a lock command (req_data ignored)
wr_en  out  1  one-cycle write strobe to register stage
wr_data  out  DATA_W  write data, valid when wr_en=1
lock_cmd  out  1  lock level to register stage (sticky)
resp_valid  out  1  one-cycle response pulse
resp_err  out  1  request denied, valid with resp_valid
viol_count  out  CNT_W  saturating count of denied writes

Behaviour:
- Reset (async, resetn=0): req_ready=0, wr_en=0, wr_data=0, lock_cmd=0, resp_valid=0, resp_err=0, viol_count=0, FSM=IDLE, lock bit=0. All outputs are registered.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, capture req_data, req_trusted and req_lock, then go to CHECK.
  - CHECK: req_ready=0.
    - If req_lock: set the lock bit, go to RESP with err=0.
    - Else if lock bit=0 or trusted=1: go to WRITE.
    - Else: go to RESP with err=1 and increment viol_count.
  - WRITE: wr_en=1 for exactly one cycle, wr_data=captured data; then go to RESP with err=0.
  - RESP: resp_valid=1 for one cycle, resp_err as decided; then go to IDLE.
- Latency from accept edge: write = 3 cycles (CHECK, WRITE, RESP); lock or denied = 2 cycles. Throughput: at most one request per 3-4 cycles.
- Lock bit:
  - Sticky. It is cleared only by resetn.
  - A lock request while already locked succeeds (err=0) with no change.
  - lock_cmd equals the lock bit, asserted from the cycle after CHECK of the lock request.
- Trust is sampled only at accept. Changes to req_trusted while the request is in flight are ignored.
- Untrusted write while unlocked succeeds (err=0, wr_en pulses).
- viol_count saturates at 2^CNT_W-1 and never wraps. It increments only on denied writes, not on lock requests.
- req_data/req_trusted/req_lock are don't-care when req_valid=0. A held req_valid after acceptance is a new request only once back in IDLE.
- Reset mid-operation:
  - Any in-flight request is dropped with no wr_en and no resp_valid.
  - The lock bit clears and lock_cmd deasserts immediately (async).
- wr_en and the lock_cmd rising edge never occur in the same cycle.

Decomposition:
- Shared package lock_pkg holds:
  - FSM state enum (IDLE, CHECK, WRITE, RESP)
  - default DATA_W=16
  - response code constants RESP_OK=0, RESP_DENIED=1
- One natural sub-module: sat_counter (parameterised width, inc, async active-low clear), used for viol_count.

Test Plan:
- Reset, then trusted=0 write 0xA5A5 while unlocked -> wr_en pulses once with wr_data=0xA5A5 on cycle 2 after accept; resp_valid with resp_err=0 on cycle 3.
- Lock request -> lock_cmd=1 from 2 cycles after accept; resp_err=0. Untrusted write 0x1234 -> no wr_en, resp_err=1, viol_count=1.
- Locked, trusted write 0xBEEF -> wr_en with 0xBEEF, resp_err=0, viol_count unchanged.
- CNT_W=2, 5 untrusted writes after lock -> viol_count 1,2,3,3,3; never 0.
- Assert resetn=0 during WRITE of 0x5555 -> wr_en, resp_valid and lock_cmd all 0 immediately. After release: req_ready=1, viol_count=0, and an untrusted write succeeds.
- Back-to-back requests with req_valid held high -> req_ready low in CHECK/WRITE/RESP; exactly one wr_en per accepted request; second request accepted only in IDLE.
